// File: rtl/ir_nec_pkg.sv
// ir_nec_pkg: NEC frame state encoding and segment lengths in protocol units
package ir_nec_pkg;
    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } state_e;
    localparam int unsigned LEAD_MARK_U  = 16;
    localparam int unsigned LEAD_SPACE_U = 8;
    localparam int unsigned RPT_SPACE_U  = 4;
    localparam int unsigned BIT_MARK_U   = 1;
    localparam int unsigned ZERO_SPACE_U = 1;
    localparam int unsigned ONE_SPACE_U  = 3;
    localparam int unsigned STOP_U       = 1;
    function automatic logic is_mark(input state_e s);
        return s == LEAD_MARK || s == BIT_MARK || s == STOP_MARK;
    endfunction
endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: square-wave carrier; carrier is the phase for the next cycle, high first after restart
module ir_carrier_gen #(
    parameter int unsigned CARRIER_HALF = 658
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic en,
    output logic carrier
);
    localparam int unsigned CW = $clog2(CARRIER_HALF + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ph_q;
    logic          wrap;
    always_comb begin
        wrap    = cnt_q == CW'(CARRIER_HALF - 1);
        cnt_d   = restart || wrap ? '0 : cnt_q + 1'b1;
        carrier = restart ? 1'b1 : ph_q ^ wrap;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ph_q  <= 1'b0;
        end else if (restart || en) begin
            cnt_q <= cnt_d;
            ph_q  <= carrier;
        end
    end
endmodule

// File: rtl/ir_nec_transmitter.sv
// ir_nec_transmitter: NEC IR frame encoder with carrier-modulated registered output
module ir_nec_transmitter
    import ir_nec_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES  = 28125,
    parameter int unsigned CARRIER_HALF = 658,
    parameter int unsigned GAP_UNITS    = 72
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        repeat_code,
    input  logic [15:0] custom_code,
    input  logic [7:0]  key_code,
    output logic        busy,
    output logic        done,
    output logic        ir_env,
    output logic        ir_tx
);
    localparam int unsigned UW      = $clog2(UNIT_CYCLES + 1);
    localparam int unsigned SEG_MAX = GAP_UNITS > LEAD_MARK_U ? GAP_UNITS : LEAD_MARK_U;
    localparam int unsigned SW      = $clog2(SEG_MAX + 1);
    state_e        state_q, state_d;
    logic [UW-1:0] unit_q, unit_d;
    logic [SW-1:0] seg_q, seg_d, seg_len;
    logic [31:0]   word_q, word_d;
    logic [4:0]    bit_q, bit_d;
    logic          rpt_q, rpt_d, env_q, env_d, tx_q, carrier, unit_last, seg_end;
    always_comb begin
        seg_len   = state_q == LEAD_MARK  ? SW'(LEAD_MARK_U)
                  : state_q == LEAD_SPACE ? SW'(rpt_q ? RPT_SPACE_U : LEAD_SPACE_U)
                  : state_q == BIT_SPACE  ? SW'(word_q[0] ? ONE_SPACE_U : ZERO_SPACE_U)
                  : state_q == GAP        ? SW'(GAP_UNITS)
                  : state_q == BIT_MARK   ? SW'(BIT_MARK_U) : SW'(STOP_U);
        unit_last = unit_q == UW'(UNIT_CYCLES - 1);
        seg_end   = unit_last && seg_q == seg_len - 1'b1;
        state_d   = state_q;
        word_d    = word_q;
        bit_d     = bit_q;
        rpt_d     = rpt_q;
        unit_d    = state_q == IDLE || unit_last ? '0 : unit_q + 1'b1;
        seg_d     = state_q == IDLE || seg_end ? '0 : seg_q + SW'(unit_last);
        if (state_q == IDLE) begin
            if (start) begin
                state_d = LEAD_MARK;
                word_d  = {~key_code, key_code, custom_code};
                bit_d   = '0;
                rpt_d   = repeat_code;
            end
        end else if (seg_end) begin
            case (state_q)
                LEAD_MARK:  state_d = LEAD_SPACE;
                LEAD_SPACE: state_d = rpt_q ? STOP_MARK : BIT_MARK;
                BIT_MARK:   state_d = BIT_SPACE;
                BIT_SPACE: begin
                    state_d = bit_q == 5'd31 ? STOP_MARK : BIT_MARK;
                    bit_d   = bit_q + 1'b1;
                    word_d  = word_q >> 1;
                end
                STOP_MARK:  state_d = GAP;
                default:    state_d = IDLE;
            endcase
        end
        env_d = is_mark(state_d);
    end
    ir_carrier_gen #(.CARRIER_HALF(CARRIER_HALF)) u_carrier (
        .clk     (clk),
        .rst     (rst),
        .restart (env_d & ~env_q),
        .en      (env_d),
        .carrier (carrier)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            unit_q  <= '0;
            seg_q   <= '0;
            word_q  <= '0;
            bit_q   <= '0;
            rpt_q   <= 1'b0;
            env_q   <= 1'b0;
            tx_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            unit_q  <= unit_d;
            seg_q   <= seg_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            rpt_q   <= rpt_d;
            env_q   <= env_d;
            tx_q    <= env_d & carrier;
        end
    end
    assign busy   = state_q != IDLE;
    assign done   = state_q == GAP && seg_end;
    assign ir_env = env_q;
    assign ir_tx  = tx_q;
endmodule

// File: tb/tb_ir_nec_transmitter.sv
// tb_ir_nec_transmitter: directed frame checks of envelope, carrier, busy and done
module tb_ir_nec_transmitter;
    localparam int UNIT = 4;
    localparam int GAPU = 2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        repeat_code = 1'b0;
    logic [15:0] custom_code = '0;
    logic [7:0]  key_code = '0;
    logic        busy, done, ir_env, ir_tx;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        exp_q[$];
    ir_nec_transmitter #(.UNIT_CYCLES(UNIT), .CARRIER_HALF(1), .GAP_UNITS(GAPU)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .repeat_code (repeat_code),
        .custom_code (custom_code),
        .key_code    (key_code),
        .busy        (busy),
        .done        (done),
        .ir_env      (ir_env),
        .ir_tx       (ir_tx)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask
    function automatic void add(input logic v, input int units);
        for (int i = 0; i < units * UNIT; i++) exp_q.push_back(v);
    endfunction
    function automatic void build(input logic [31:0] w, input logic rpt);
        exp_q.delete();
        add(1'b1, 16);
        add(1'b0, rpt ? 4 : 8);
        if (!rpt)
            for (int b = 0; b < 32; b++) begin
                add(1'b1, 1);
                add(1'b0, w[b] ? 3 : 1);
            end
        add(1'b1, 1);
        add(1'b0, GAPU);
    endfunction
    task automatic send(input logic [15:0] c, input logic [7:0] k, input logic r);
        custom_code = c;
        key_code    = k;
        repeat_code = r;
        start       = 1'b1;
        build({~k, k, c}, r);
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic run_frame(input int pulse_at, input int abort_at);
        int   k = 0;
        int   n = exp_q.size();
        logic prev = 1'b0;
        logic e;
        for (int i = 0; i < n; i++) begin
            e    = exp_q[i];
            k    = (e && !prev) ? 0 : k + 1;
            prev = e;
            chk("env", ir_env, e);
            chk("tx", ir_tx, e & (k % 2 == 0));
            chk("busy", busy, 1'b1);
            chk("done", done, i == n - 1);
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            start = (i == pulse_at) || (pulse_at >= 0 && i == n - 1);
            if (start) begin
                custom_code = 16'h0000;
                key_code    = 8'hFF;
                repeat_code = 1'b1;
            end
            @(negedge clk);
        end
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_env"}, ir_env, 1'b0);
        chk({tag, "_tx"}, ir_tx, 1'b0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("idle");
        send(16'h6B86, 8'h12, 1'b0);
        run_frame(100, -1);
        chk_idle("done_cycle_start");
        build(32'h0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        run_frame(-1, -1);
        chk_idle("after_repeat");
        send(16'h00FF, 8'h1A, 1'b0);
        run_frame(-1, 240);
        chk_idle("abort");
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk_idle("post_abort");
        end
        send(16'hA55A, 8'h3C, 1'b0);
        run_frame(-1, -1);
        chk_idle("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
